// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the two-client burst memory arbiter.
// Both the top-level FSM and the round-robin grant logic import this package.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        I_BURST = 2'd1,
        D_BURST = 2'd2
    } arb_state_t;

    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } grant_t;

    localparam int BURST_LEN_DEF = 4;

    // Byte-offset bits covered by one line: word index bits plus the two byte bits.
    function automatic int off_bits(input int burst_len);
        return $clog2(burst_len) + 2;
    endfunction

    localparam int OFF_BITS = off_bits(BURST_LEN_DEF);

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a lone request wins outright, a tie goes to
// the side that was not served last. Purely combinational, one-hot output.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] gnt
);

    // Grant selection; bit 0 is the I-side, bit 1 the D-side.
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01: gnt = 2'b01;
            2'b10: gnt = 2'b10;
            2'b11: begin
                if (last_grant == GNT_I) begin
                    gnt = 2'b10;
                end else begin
                    gnt = 2'b01;
                end
            end
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one backing-memory port between I-cache refills and D-cache
// refills/writebacks, running each grant as a fixed-length line burst.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int BURST_LEN = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_req,
    input  logic [WIDTH-1:0] i_addr,
    output logic [WIDTH-1:0] i_rdata,
    output logic             i_rvalid,
    output logic             i_done,
    input  logic             d_req,
    input  logic             d_we,
    input  logic [WIDTH-1:0] d_addr,
    input  logic [WIDTH-1:0] d_wdata,
    output logic             d_wready,
    output logic [WIDTH-1:0] d_rdata,
    output logic             d_rvalid,
    output logic             d_done,
    output logic             mem_valid,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic             mem_ready,
    input  logic [WIDTH-1:0] mem_rdata
);

    localparam int BEAT_W = $clog2(BURST_LEN);
    localparam int OFF_W  = off_bits(BURST_LEN);
    localparam logic [WIDTH-1:0]  LINE_MASK = {WIDTH{1'b1}} << OFF_W;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);
    localparam logic [BEAT_W-1:0] BEAT_ONE  = BEAT_W'(1);
    localparam logic [BEAT_W-1:0] BEAT_ZERO = BEAT_W'(0);

    arb_state_t        state_r;
    arb_state_t        next_state_s;
    logic [BEAT_W-1:0] beat_r;
    logic [WIDTH-1:0]  base_r;
    logic              we_r;
    grant_t            last_grant_r;
    logic [1:0]        gnt_s;
    logic              accept_s;
    logic              last_beat_s;
    logic              grant_any_s;
    logic [WIDTH-1:0]  offset_s;

    rr_arb2 u_rr_arb2 (
        .req        ({d_req, i_req}),
        .last_grant (last_grant_r),
        .gnt        (gnt_s)
    );

    assign accept_s    = (state_r != IDLE) && mem_ready;
    assign last_beat_s = (beat_r == LAST_BEAT);
    assign grant_any_s = (state_r == IDLE) && (gnt_s != 2'b00);
    // Base has its low OFF_W bits cleared, so OR-ing the offset never carries out of the line.
    assign offset_s    = {{(WIDTH-BEAT_W-2){1'b0}}, beat_r, 2'b00};

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic: grant from IDLE, leave a burst on its last accepted beat.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (gnt_s[0]) begin
                    next_state_s = I_BURST;
                end else if (gnt_s[1]) begin
                    next_state_s = D_BURST;
                end else begin
                    next_state_s = IDLE;
                end
            end
            I_BURST, D_BURST: begin
                if (accept_s && last_beat_s) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = state_r;
                end
            end
            default: next_state_s = IDLE;
        endcase
    end

    // Beat counter: advances only on accepted beats and wraps at end of line.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            beat_r <= BEAT_ZERO;
        end else if (accept_s) begin
            if (last_beat_s) begin
                beat_r <= BEAT_ZERO;
            end else begin
                beat_r <= beat_r + BEAT_ONE;
            end
        end else begin
            beat_r <= beat_r;
        end
    end

    // Request capture: line base, direction and fairness history, sampled only at grant.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            base_r       <= {WIDTH{1'b0}};
            we_r         <= 1'b0;
            last_grant_r <= GNT_I;
        end else if (grant_any_s) begin
            if (gnt_s[1]) begin
                base_r       <= d_addr & LINE_MASK;
                we_r         <= d_we;
                last_grant_r <= GNT_D;
            end else begin
                base_r       <= i_addr & LINE_MASK;
                we_r         <= 1'b0;
                last_grant_r <= GNT_I;
            end
        end else begin
            base_r       <= base_r;
            we_r         <= we_r;
            last_grant_r <= last_grant_r;
        end
    end

    // Memory-side and client-side outputs, decoded from state and the memory handshake.
    always_comb begin
        mem_valid = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = {WIDTH{1'b0}};
        mem_wdata = d_wdata;
        i_rdata   = mem_rdata;
        d_rdata   = mem_rdata;
        i_rvalid  = 1'b0;
        i_done    = 1'b0;
        d_rvalid  = 1'b0;
        d_wready  = 1'b0;
        d_done    = 1'b0;
        case (state_r)
            I_BURST: begin
                mem_valid = 1'b1;
                mem_addr  = base_r | offset_s;
                i_rvalid  = mem_ready;
                i_done    = mem_ready & last_beat_s;
            end
            D_BURST: begin
                mem_valid = 1'b1;
                mem_we    = we_r;
                mem_addr  = base_r | offset_s;
                d_rvalid  = mem_ready & ~we_r;
                d_wready  = mem_ready & we_r;
                d_done    = mem_ready & last_beat_s;
            end
            IDLE: begin
                mem_valid = 1'b0;
            end
            default: begin
                mem_valid = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fairness, burst addressing, writes,
// wait states, mid-burst request changes and asynchronous reset.
module tb_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_rvalid;
    logic        i_done;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_wready;
    logic [31:0] d_rdata;
    logic        d_rvalid;
    logic        d_done;
    logic        mem_valid;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    int errors = 0;
    int checks = 0;

    mem_arbiter #(.WIDTH(32), .BURST_LEN(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_rdata   (i_rdata),
        .i_rvalid  (i_rvalid),
        .i_done    (i_done),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_wready  (d_wready),
        .d_rdata   (d_rdata),
        .d_rvalid  (d_rvalid),
        .d_done    (d_done),
        .mem_valid (mem_valid),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory returns a pattern tied to the address so each beat's data is distinct.
    assign mem_rdata = mem_addr ^ 32'hDEAD_0000;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One full burst with mem_ready held high; first beat lands on the next negedge.
    task automatic burst(input string tag, input logic side_d, input logic we,
                         input logic [31:0] base, input logic drop);
        logic [31:0] ea;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (we) d_wdata = 32'h0000_00A0 + 32'(k);
            if (drop && k == 3) begin
                if (side_d) d_req = 1'b0;
                else        i_req = 1'b0;
            end
            #1;
            ea = base + 32'(k * 4);
            chk($sformatf("%s_valid%0d", tag, k), {31'd0, mem_valid}, 32'd1);
            chk($sformatf("%s_addr%0d", tag, k), mem_addr, ea);
            chk($sformatf("%s_we%0d", tag, k), {31'd0, mem_we}, {31'd0, we});
            if (side_d) begin
                chk($sformatf("%s_drv%0d", tag, k), {31'd0, d_rvalid}, {31'd0, ~we});
                chk($sformatf("%s_wrdy%0d", tag, k), {31'd0, d_wready}, {31'd0, we});
                chk($sformatf("%s_ddone%0d", tag, k), {31'd0, d_done}, (k == 3) ? 32'd1 : 32'd0);
                chk($sformatf("%s_irv%0d", tag, k), {31'd0, i_rvalid}, 32'd0);
                if (we) chk($sformatf("%s_wdata%0d", tag, k), mem_wdata, 32'h0000_00A0 + 32'(k));
                else    chk($sformatf("%s_rdata%0d", tag, k), d_rdata, ea ^ 32'hDEAD_0000);
            end else begin
                chk($sformatf("%s_irv%0d", tag, k), {31'd0, i_rvalid}, 32'd1);
                chk($sformatf("%s_idone%0d", tag, k), {31'd0, i_done}, (k == 3) ? 32'd1 : 32'd0);
                chk($sformatf("%s_rdata%0d", tag, k), i_rdata, ea ^ 32'hDEAD_0000);
                chk($sformatf("%s_drv%0d", tag, k), {31'd0, d_rvalid}, 32'd0);
            end
        end
    endtask

    task automatic idle_chk(input string tag);
        @(negedge clk);
        #1;
        chk({tag, "_valid"}, {31'd0, mem_valid}, 32'd0);
        chk({tag, "_done"}, {30'd0, i_done, d_done}, 32'd0);
    endtask

    logic [6:0]  rdy_pat;
    int          beat;
    logic [31:0] ea;

    initial begin
        rst = 1'b0; i_req = 1'b0; i_addr = 32'd0; d_req = 1'b0; d_we = 1'b0;
        d_addr = 32'd0; d_wdata = 32'd0; mem_ready = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_valid", {31'd0, mem_valid}, 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_flags", {26'd0, mem_we, d_wready, i_rvalid, d_rvalid, i_done, d_done}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Tie out of reset: D first; D keeps requesting, so the next tie goes to I.
        @(negedge clk);
        i_req = 1'b1; i_addr = 32'h0000_0400;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0300;
        #1;
        chk("tie_idle", {31'd0, mem_valid}, 32'd0);
        burst("tieD", 1'b1, 1'b0, 32'h0000_0300, 1'b0);
        idle_chk("tieD_gap");
        burst("tieI", 1'b0, 1'b0, 32'h0000_0400, 1'b1);
        idle_chk("tieI_gap");
        burst("tieD2", 1'b1, 1'b0, 32'h0000_0300, 1'b1);
        idle_chk("tieD2_gap");

        // I-only read at 0x100
        @(negedge clk);
        i_req = 1'b1; i_addr = 32'h0000_0100;
        burst("ird", 1'b0, 1'b0, 32'h0000_0100, 1'b1);
        idle_chk("ird_gap");

        // D write with low address bits set
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_020C;
        #1;
        chk("dwr_idle", {31'd0, d_wready}, 32'd0);
        burst("dwr", 1'b1, 1'b1, 32'h0000_0200, 1'b1);
        idle_chk("dwr_gap");
        d_we = 1'b0;

        // Wait states, with i_addr changed and i_req dropped mid-burst
        @(negedge clk);
        i_req = 1'b1; i_addr = 32'h0000_0600;
        rdy_pat = 7'b1011001;
        beat = 0;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            mem_ready = rdy_pat[c];
            if (c == 2) begin
                i_addr = 32'h0000_0900;
                i_req  = 1'b0;
            end
            #1;
            ea = 32'h0000_0600 + 32'(beat * 4);
            chk($sformatf("ws_addr%0d", c), mem_addr, ea);
            chk($sformatf("ws_rv%0d", c), {31'd0, i_rvalid}, {31'd0, rdy_pat[c]});
            chk($sformatf("ws_done%0d", c), {31'd0, i_done},
                (rdy_pat[c] && beat == 3) ? 32'd1 : 32'd0);
            if (rdy_pat[c]) beat++;
        end
        chk("ws_beats", 32'(beat), 32'd4);
        @(negedge clk);
        mem_ready = 1'b1;
        #1;
        chk("ws_end_idle", {31'd0, mem_valid}, 32'd0);

        // Asynchronous reset after two beats of a D read
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0500;
        @(negedge clk);
        #1;
        chk("rs_b0", mem_addr, 32'h0000_0500);
        @(negedge clk);
        #1;
        chk("rs_b1", mem_addr, 32'h0000_0504);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rs_valid", {31'd0, mem_valid}, 32'd0);
        chk("rs_drv", {31'd0, d_rvalid}, 32'd0);
        chk("rs_addr", mem_addr, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rs_idle", {31'd0, mem_valid}, 32'd0);
        burst("rsD", 1'b1, 1'b0, 32'h0000_0500, 1'b1);
        idle_chk("rsD_gap");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates a single backing-memory port between the instruction-cache refill path (I-side, read-only) and the data-cache refill/writeback path (D-side, read or write). Each granted request runs as a fixed-length line burst, and the arbiter sequences the beat addresses. The block sits below both caches, in place of two private memories. Ties are resolved round-robin so neither side starves.

## Interface
- `WIDTH`, 32: data and address width.
- `BURST_LEN`, 4: words per line; power of two, ≥2.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous, active-low (0 = reset).
- `i_req`  in  1  I-side line-read request; held until `i_done`.
- `i_addr`  in  WIDTH  I-side line address; low `log2(BURST_LEN)+2` bits ignored.
- `i_rdata`  out  WIDTH  I-side beat data.
- `i_rvalid`  out  1  I-side beat valid.
- `i_done`  out  1  pulse on the final I-side beat.
- `d_req`  in  1  D-side line request; held until `d_done`.
- `d_we`  in  1  D-side direction: 1 = write burst, 0 = read burst.
- `d_addr`  in  WIDTH  D-side line address; low bits ignored.
- `d_wdata`  in  WIDTH  D-side write beat; must be valid while `d_wready` = 1.
- `d_wready`  out  1  D-side write beat consumed this cycle.
- `d_rdata`  out  WIDTH  D-side beat data.
- `d_rvalid`  out  1  D-side beat valid.
- `d_done`  out  1  pulse on the final D-side beat.
- `mem_valid`  out  1  beat request to the backing memory.
- `mem_we`  out  1  beat direction.
- `mem_addr`  out  WIDTH  word address of the beat.
- `mem_wdata`  out  WIDTH  write data; equals `d_wdata`.
- `mem_ready`  in  1  beat accepted; for reads, `mem_rdata` is valid in the same cycle.
- `mem_rdata`  in  WIDTH  read data.

## Operation
- States: IDLE, I_BURST, D_BURST.
- IDLE with exactly one request: latch that request's line address (low bits zeroed) and `d_we`, then move to that side's BURST state.
- IDLE with both requesting: grant the side not served last. The `last_grant` register resets to I, so D wins the first tie.
- `last_grant` updates on entry to a BURST state.
- In a BURST state, `mem_valid` = 1.
- `mem_addr` = latched base + (beat × 4).
- `beat` is a counter of width log2(BURST_LEN); it increments on `mem_valid & mem_ready`.
- Read beat accepted: `mem_rdata` passes combinationally to the granted side's `rdata`, and that side's `rvalid` = 1 in the same cycle.
- D write beat accepted: `d_wready` = 1 in the same cycle. The requester advances to its next word.
- When the accepted beat has `beat == BURST_LEN-1`:
  - assert the granted side's `done` in that cycle;
  - reset `beat` to 0;
  - return to IDLE.
- Requests, `d_we` and addresses are sampled only in IDLE. Changes during a burst are ignored, and a dropped request does not abort the burst.
- `mem_ready` is ignored whenever `mem_valid` = 0.
- After `done`, the requester must deassert `req` by the next edge. A `req` still high in IDLE is treated as a new request.

## Timing
- Reset values:
  - state IDLE, `beat` = 0, `last_grant` = I;
  - `mem_valid`, `mem_we`, `d_wready`, `i_rvalid`, `d_rvalid`, `i_done`, `d_done` all 0;
  - `mem_addr` = 0.
- Reset mid-burst: outputs drop immediately (asynchronous). No partial-burst completion.
- Grant latency: request high at edge N in IDLE gives `mem_valid` = 1 from cycle N+1.
- Minimum burst: BURST_LEN cycles with `mem_ready` held at 1.
- Wait states: `mem_ready` = 0 holds address, beat and direction stable.
- Back-to-back: at least one IDLE cycle between bursts. Cycles per line ≥ BURST_LEN+1.
- Address arithmetic: beat offsets never carry into the line-index bits (no wrap past the line).
- All outputs are combinational from state, `beat`, latched registers and `mem_ready`/`mem_rdata`. There is no internal pipeline register on data.

## Structure
- Package `mem_arb_pkg`:
  - state enum `arb_state_t` {IDLE, I_BURST, D_BURST};
  - `grant_t` {GNT_I, GNT_D};
  - `OFF_BITS` = log2(BURST_LEN)+2.
- One sub-module: `rr_arb2`. It takes two request bits and `last_grant` and returns a one-hot grant; it is combinational.
- The burst counter and FSM live in the top module.

## Test plan
- I-only read, base 0x100, `mem_ready` = 1 → addresses 0x100/104/108/10C, 4 `i_rvalid` pulses, `i_done` on the 4th beat, IDLE one cycle later.
- Simultaneous `i_req`/`d_req` out of reset → D granted first, I granted after the D burst plus 1 IDLE cycle. A second tie → I granted.
- D write, base 0x20C (low bits ignored → 0x200), `d_wdata` 0xA0..0xA3 → `mem_we` = 1, writes land at 0x200..0x20C in order, `d_wready` pulses 4 times.
- `mem_ready` toggled 1,0,0,1,1,0,1 during an I burst → `mem_addr` stable during wait cycles, exactly 4 beats, `i_done` only on the last.
- `rst` asserted low after beat 2 of a D burst → `mem_valid` = 0 immediately. After release, state is IDLE, `beat` = 0, and a new request starts at beat 0.
- `i_addr` changed mid-burst and `i_req` dropped mid-burst → burst completes on the original line address.
